// File: rtl/conv_sequencer.sv
// conv_sequencer: instruction sequencer for core
// Runs one weight-stationary convolution pass per start pulse.
module conv_sequencer #(
  parameter int          row      = 8,
  parameter int          col      = 8,
  parameter int          len_kij  = 9,
  parameter int          len_nij  = 36,
  parameter int          len_onij = 16,
  parameter logic [10:0] w_base   = 11'd64,
  parameter logic [10:0] x_base   = 11'd0,
  parameter logic [10:0] p_base   = 11'd0,
  parameter int          load_gap = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_idx
);

  if (row < 1 || col < 1 || len_kij < 1 || len_kij > 16 ||
      len_nij < 1 || len_onij < 1 || load_gap < 1) begin : g_bad_cfg
    $error("conv_sequencer: illegal size parameter");
  end

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = imax(imax(col, load_gap),
                             imax(len_nij, len_onij));
  localparam int CW = $clog2(MAXC + 1);
  localparam int KW = $clog2(len_kij + 1);

  localparam logic [CW-1:0] COL_L  = CW'(col - 1);
  localparam logic [CW-1:0] GAP_L  = CW'(load_gap - 1);
  localparam logic [CW-1:0] NIJ_L  = CW'(len_nij - 1);
  localparam logic [CW-1:0] ONIJ_L = CW'(len_onij - 1);
  localparam logic [KW-1:0] KIJ_L  = KW'(len_kij - 1);

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_WLD, S_WTAIL, S_KLOAD, S_KGAP, S_XLD,
    S_XTAIL, S_EXEC, S_DRAIN, S_ORD, S_OTAIL, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] kij, kij_n;
  logic          pend, pend_n;
  logic [CW-1:0] wr_o, wr_o_n;

  logic [33:0] inst_n;
  logic        busy_n, done_n;

  logic        acc_b, cen_p, wen_p, cen_x, wen_x;
  logic [10:0] a_p, a_x;
  logic        ord, l0rd, l0wr, exe, ld;

  // next state, counters and the instruction for the current state
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    kij_n   = kij;
    pend_n  = pend;
    wr_o_n  = wr_o;
    busy_n  = (state != S_IDLE) && (state != S_DONE);
    done_n  = 1'b0;
    acc_b   = 1'b0;
    cen_p   = 1'b1;
    wen_p   = 1'b1;
    a_p     = '0;
    cen_x   = 1'b1;
    wen_x   = 1'b1;
    a_x     = '0;
    ord     = 1'b0;
    l0rd    = 1'b0;
    l0wr    = 1'b0;
    exe     = 1'b0;
    ld      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_WLD;
          cnt_n   = '0;
          kij_n   = '0;
        end
      end
      S_WLD: begin
        cen_x = 1'b0;
        a_x   = w_base + 11'(int'(kij) * col) + 11'(cnt);
        l0wr  = (cnt != '0);
        if (cnt == COL_L) begin
          cnt_n   = '0;
          state_n = S_WTAIL;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WTAIL: begin
        l0wr    = 1'b1;
        state_n = S_KLOAD;
      end
      S_KLOAD: begin
        l0rd = 1'b1;
        ld   = 1'b1;
        if (cnt == COL_L) begin
          cnt_n   = '0;
          state_n = S_KGAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_KGAP: begin
        if (cnt == GAP_L) begin
          cnt_n   = '0;
          state_n = S_XLD;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_XLD: begin
        cen_x = 1'b0;
        a_x   = x_base + 11'(cnt);
        l0wr  = (cnt != '0);
        if (cnt == NIJ_L) begin
          cnt_n   = '0;
          state_n = S_XTAIL;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_XTAIL: begin
        l0wr    = 1'b1;
        state_n = S_EXEC;
      end
      S_EXEC: begin
        l0rd = 1'b1;
        exe  = 1'b1;
        if (cnt == NIJ_L) begin
          cnt_n   = '0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) state_n = S_ORD;
      end
      S_ORD: begin
        // the previous pop's write may ride along with this pop
        if (pend) begin
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = p_base + 11'(wr_o);
          acc_b = (kij != '0);
        end
        pend_n = ofifo_valid;
        if (ofifo_valid) begin
          ord    = 1'b1;
          wr_o_n = cnt;
          if (cnt == ONIJ_L) begin
            cnt_n   = '0;
            state_n = S_OTAIL;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_OTAIL: begin
        cen_p  = 1'b0;
        wen_p  = 1'b0;
        a_p    = p_base + 11'(wr_o);
        acc_b  = (kij != '0);
        pend_n = 1'b0;
        if (kij == KIJ_L) begin
          state_n = S_DONE;
        end else begin
          kij_n   = kij + 1'b1;
          state_n = S_WLD;
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    inst_n = {acc_b, cen_p, wen_p, a_p,
              cen_x, wen_x, a_x,
              ord, 1'b0, 1'b0,
              l0rd, l0wr, exe, ld};
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      kij     <= '0;
      pend    <= 1'b0;
      wr_o    <= '0;
      inst    <= IDLE_INST;
      busy    <= 1'b0;
      done    <= 1'b0;
      kij_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      kij     <= kij_n;
      pend    <= pend_n;
      wr_o    <= wr_o_n;
      inst    <= inst_n;
      busy    <= busy_n;
      done    <= done_n;
      kij_idx <= 4'(kij);
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: self-checking bench for conv_sequencer
// Timing tables, drain/reset sequences and scoreboarded full passes.
module tb_conv_sequencer;

  localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
  localparam logic [33:0] L0RD   = 34'h8;
  localparam logic [33:0] L0WR   = 34'h4;
  localparam logic [33:0] EXE    = 34'h2;
  localparam logic [33:0] LOAD   = 34'h1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  int n_tests = 0;
  int n_fail  = 0;

  conv_sequencer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .ofifo_valid(ofifo_valid),
    .inst(inst),
    .busy(busy),
    .done(done),
    .kij_idx(kij_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_n(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [33:0] xrd(input int a);
    logic [33:0] w;
    w = IDLE_I;
    w[19] = 1'b0;
    w[17:7] = 11'(a);
    return w;
  endfunction

  typedef struct {
    int          cyc;
    logic [33:0] inst;
  } vec_t;

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic t_reset_idle();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("idle_c%0d", c),
          64'({busy, done, kij_idx, inst}),
          64'({1'b0, 1'b0, 4'd0, IDLE_I}));
    end
  endtask

  task automatic t_first_kij();
    vec_t tbl[$];
    vec_t v;
    int pops, wr, bad;
    bit popprev, vprev;
    for (int k = 1; k <= 98; k++) begin
      v.cyc = k;
      if (k <= 8)       v.inst = xrd(64 + k - 1) | ((k >= 2) ? L0WR : 34'h0);
      else if (k == 9)  v.inst = IDLE_I | L0WR;
      else if (k <= 17) v.inst = IDLE_I | L0RD | LOAD;
      else if (k <= 25) v.inst = IDLE_I;
      else if (k <= 61) v.inst = xrd(k - 26) | ((k >= 27) ? L0WR : 34'h0);
      else if (k == 62) v.inst = IDLE_I | L0WR;
      else              v.inst = IDLE_I | L0RD | EXE;
      tbl.push_back(v);
    end
    ofifo_valid = 1'b0;
    pulse_start();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("seq_c%0d", tbl[i].cyc),
          64'({busy, kij_idx, inst}),
          64'({1'b1, 4'd0, tbl[i].inst}));
    end
    for (int c = 99; c <= 148; c++) begin
      @(negedge clk);
      chk($sformatf("drain_idle_c%0d", c),
          64'({busy, inst}), 64'({1'b1, IDLE_I}));
    end
    ofifo_valid = 1'b1;
    pops = 0;
    wr = 0;
    bad = 0;
    popprev = 1'b0;
    for (int c = 0; c < 100 && wr < 16; c++) begin
      @(negedge clk);
      vprev = ofifo_valid;
      if (inst[6]) begin
        pops++;
        if (!vprev) bad++;
      end
      if (!inst[32]) begin
        if (!popprev) bad++;
        chk($sformatf("drain_wr%0d", wr),
            64'({inst[33], inst[31], inst[30:20]}),
            64'({1'b0, 1'b0, 11'(wr)}));
        wr++;
      end
      popprev = inst[6];
      ofifo_valid = ~ofifo_valid;
    end
    chk_n("drain_pops", pops, 16);
    chk_n("drain_writes", wr, 16);
    chk_n("drain_rules", bad, 0);
    @(negedge clk);
    chk("kij1_first_wld", 64'({kij_idx, inst}), 64'({4'd1, xrd(72)}));
    reset = 1'b0;
    ofifo_valid = 1'b0;
    @(negedge clk);
    chk("reset_mid_pass", 64'({busy, done, kij_idx, inst}),
        64'({1'b0, 1'b0, 4'd0, IDLE_I}));
    reset = 1'b1;
  endtask

  task automatic t_reset_exec();
    pulse_start();
    repeat (70) @(negedge clk);
    chk("exec_active", 64'({busy, inst}), 64'({1'b1, IDLE_I | L0RD | EXE}));
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("reset_exec", 64'({busy, done, inst}), 64'({1'b0, 1'b0, IDLE_I}));
    start = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("start_in_reset_c%0d", c),
          64'({busy, inst}), 64'({1'b0, IDLE_I}));
    end
  endtask

  task automatic run_pass(input bit rnd);
    int xq[$];
    int pq[$];
    bit aq[$];
    int k, done_k, n_done, pops, n_ld, n_ex, n_rd, n_wr;
    int bad, last_kij, tail, ea;
    bit vprev, popprev, seen_done, eacc;
    for (int j = 0; j < 9; j++) begin
      for (int i = 0; i < 8; i++) xq.push_back(64 + j * 8 + i);
      for (int n = 0; n < 36; n++) xq.push_back(n);
      for (int o = 0; o < 16; o++) begin
        pq.push_back(o);
        aq.push_back(j != 0);
      end
    end
    k = 0; done_k = 0; n_done = 0; pops = 0;
    n_ld = 0; n_ex = 0; n_rd = 0; n_wr = 0;
    bad = 0; last_kij = 0; tail = 0;
    popprev = 1'b0;
    seen_done = 1'b0;
    ofifo_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    pulse_start();
    while (k < 4000 && tail < 5) begin
      @(negedge clk);
      k++;
      vprev = ofifo_valid;
      if ($isunknown(inst)) bad++;
      if (inst[0] && inst[1]) bad++;
      if (inst[5:4] != 2'b00) bad++;
      if (seen_done) begin
        tail++;
        if (busy || done || inst !== IDLE_I) bad++;
      end else begin
        n_ld += int'(inst[0]);
        n_ex += int'(inst[1]);
        n_rd += int'(inst[3]);
        n_wr += int'(inst[2]);
        if (!inst[19]) begin
          if (!inst[18]) bad++;
          if (xq.size() == 0) bad++;
          else begin
            ea = xq.pop_front();
            chk("xmem_addr", 64'(inst[17:7]), 64'(11'(ea)));
          end
        end
        if (!inst[32]) begin
          if (!popprev || inst[31]) bad++;
          if (pq.size() == 0) bad++;
          else begin
            ea = pq.pop_front();
            eacc = aq.pop_front();
            chk("pmem_wr", 64'({inst[33], inst[30:20]}),
                64'({eacc, 11'(ea)}));
          end
        end
        if (inst[6]) begin
          pops++;
          if (!vprev) bad++;
        end
        popprev = inst[6];
        if (busy && int'(kij_idx) != last_kij) begin
          if (int'(kij_idx) != last_kij + 1) bad++;
          last_kij = int'(kij_idx);
        end
        if (done) begin
          n_done++;
          done_k = k;
          seen_done = 1'b1;
          if (busy) bad++;
        end
      end
      ofifo_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = (k == 300) ||
              (rnd && k > 2 && k < 900 && $urandom_range(0, 49) == 0);
    end
    start = 1'b0;
    ofifo_valid = 1'b0;
    chk_n("pass_done_count", n_done, 1);
    chk_n("pass_pops", pops, 144);
    chk_n("pass_xmem_left", xq.size(), 0);
    chk_n("pass_pmem_left", pq.size(), 0);
    chk_n("pass_loads", n_ld, 72);
    chk_n("pass_execs", n_ex, 324);
    chk_n("pass_l0rd", n_rd, 396);
    chk_n("pass_l0wr", n_wr, 396);
    chk_n("pass_last_kij", last_kij, 8);
    chk_n("pass_rules", bad, 0);
    if (!rnd) chk_n("pass_done_cycle", done_k, 1045);
  endtask

  initial begin
    t_reset_idle();
    t_first_kij();
    t_reset_exec();
    run_pass(1'b0);
    run_pass(1'b1);
    run_pass(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
